// File: rtl/error_fifo_mc.sv
// Multi-source error-report FIFO: one-entry capture register per source, drained
// round-robin into a RAM FIFO with a show-ahead output register and drop counting.
module error_fifo_mc #(
    parameter int NSRC      = 4,
    parameter int SW        = 32,
    parameter int TAGW      = 24,
    parameter int DEPTH_LOG = 6
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [TAGW-1:0]      CPSR,
    input  logic [NSRC-1:0]      SRC_STB,
    input  logic [NSRC*SW-1:0]   SRC_ECD,
    input  logic                 ERD,
    output logic                 VALID,
    output logic [8+TAGW+SW-1:0] ECD,
    output logic [DEPTH_LOG:0]   COUNT,
    output logic                 OVF,
    output logic [15:0]          OVF_CNT,
    input  logic                 OVF_CLR
);
    localparam int EW    = 8 + TAGW + SW;
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int PW    = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [DEPTH_LOG:0] PTR_ONE = 1;

    logic [NSRC-1:0] cap_full;
    logic [NSRC-1:0] cap_lost;
    logic [NSRC-1:0] lost;
    logic [SW-1:0]   cap_payload [NSRC];
    logic [TAGW-1:0] cap_tag [NSRC];

    logic [PW-1:0]   arb_ptr;
    logic [PW-1:0]   next_ptr;
    logic            gnt_valid;
    logic [NSRC-1:0] gnt_vec;
    logic [EW-1:0]   gnt_entry;

    logic [NSRC-1:0] accept;
    logic [NSRC-1:0] drop_vec;
    logic [7:0]      drop_total;
    logic [16:0]     cnt_base;
    logic [16:0]     cnt_sum;
    logic [15:0]     cnt_next;
    logic            ovf_next;

    logic [DEPTH_LOG:0] wptr;
    logic [DEPTH_LOG:0] rptr;
    logic            ram_empty;
    logic            ram_full;
    logic            ram_wr;
    logic            out_load;
    logic [EW-1:0]   ram [DEPTH];

    // Round-robin search starting at arb_ptr; the first full capture reg wins
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_vec   = '0;
        gnt_entry = '0;
        next_ptr  = arb_ptr;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(arb_ptr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!gnt_valid && cap_full[idx]) begin
                gnt_valid    = 1'b1;
                gnt_vec[idx] = 1'b1;
                gnt_entry    = {cap_lost[idx], 7'(idx), cap_tag[idx], cap_payload[idx]};
                next_ptr     = (idx + 1 >= NSRC) ? '0 : PW'(idx + 1);
            end
        end
    end

    assign accept   = SRC_STB & (~cap_full | gnt_vec);
    assign drop_vec = SRC_STB & cap_full & ~gnt_vec;

    assign ram_empty = (wptr == rptr);
    assign ram_full  = ((wptr ^ rptr) == {1'b1, {DEPTH_LOG{1'b0}}});
    assign ram_wr    = gnt_valid & ~ram_full;
    assign out_load  = (~VALID | ERD) & ~ram_empty;

    // Capture drops plus a discarded grant all land on the counter in one cycle
    always_comb begin
        drop_total = '0;
        for (int i = 0; i < NSRC; i++) begin
            drop_total = drop_total + 8'(drop_vec[i]);
        end
        if (gnt_valid && ram_full) drop_total = drop_total + 8'd1;
    end

    assign cnt_base = OVF_CLR ? 17'd0 : {1'b0, OVF_CNT};
    assign cnt_sum  = cnt_base + {9'd0, drop_total};
    assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    assign ovf_next = (OVF & ~OVF_CLR) | (drop_total != 8'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cap_full <= '0;
            cap_lost <= '0;
            lost     <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (accept[i]) begin
                    cap_full[i] <= 1'b1;
                    cap_lost[i] <= lost[i];
                    lost[i]     <= 1'b0;
                end else begin
                    if (gnt_vec[i]) cap_full[i] <= 1'b0;
                    if (drop_vec[i]) lost[i] <= 1'b1;
                end
            end
        end
    end

    // Payload and tag are only meaningful while cap_full is set, so no reset
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NSRC; i++) begin
            if (accept[i]) begin
                cap_payload[i] <= SRC_ECD[i*SW +: SW];
                cap_tag[i]     <= CPSR;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            arb_ptr <= '0;
            wptr    <= '0;
            OVF     <= 1'b0;
            OVF_CNT <= '0;
        end else begin
            if (gnt_valid) arb_ptr <= next_ptr;
            if (ram_wr) wptr <= wptr + PTR_ONE;
            OVF     <= ovf_next;
            OVF_CNT <= cnt_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (ram_wr) ram[wptr[DEPTH_LOG-1:0]] <= gnt_entry;
    end

    // The output register doubles as the RAM read register, giving show-ahead data
    always_ff @(posedge CLK) begin
        if (RESET) begin
            VALID <= 1'b0;
            ECD   <= '0;
            rptr  <= '0;
        end else if (out_load) begin
            ECD   <= ram[rptr[DEPTH_LOG-1:0]];
            VALID <= 1'b1;
            rptr  <= rptr + PTR_ONE;
        end else if (ERD) begin
            VALID <= 1'b0;
        end
    end

    assign COUNT = (wptr - rptr) + {{DEPTH_LOG{1'b0}}, VALID};

endmodule

// File: tb/tb_error_fifo_mc.sv
// Bench for error_fifo_mc: a queue/count reference model feeds a scoreboard that
// a negedge monitor drains; a second small-depth instance covers the full-RAM case.
module tb_error_fifo_mc;
    localparam int NSRC  = 4;
    localparam int DL    = 6;
    localparam int DEPTH = 1 << DL;

    logic         clk = 1'b0;
    logic         rst;
    logic [23:0]  cpsr;
    logic [3:0]   stb;
    logic [127:0] ecd_in;
    logic         erd;
    logic         clr;
    logic         valid;
    logic [63:0]  ecd;
    logic [6:0]   count;
    logic         ovf;
    logic [15:0]  ovf_cnt;

    logic [3:0]   s_stb;
    logic [127:0] s_ecd_in;
    logic         s_erd;
    logic         s_valid;
    logic [63:0]  s_ecd;
    logic [2:0]   s_count;
    logic         s_ovf;
    logic [15:0]  s_ovf_cnt;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [63:0] exp_q[$];
    logic [63:0] small_q[$];

    bit          m_full [NSRC];
    bit          m_lostflag [NSRC];
    bit          m_caplost [NSRC];
    logic [31:0] m_pay [NSRC];
    logic [23:0] m_tag [NSRC];
    int          m_rr;
    int          m_ram_n;
    bit          m_out_v;
    int          m_ovf_cnt;
    bit          m_ovf;

    always #5 clk = ~clk;

    error_fifo_mc #(.NSRC(4), .SW(32), .TAGW(24), .DEPTH_LOG(DL)) dut (
        .CLK(clk), .RESET(rst), .CPSR(cpsr), .SRC_STB(stb), .SRC_ECD(ecd_in),
        .ERD(erd), .VALID(valid), .ECD(ecd), .COUNT(count), .OVF(ovf),
        .OVF_CNT(ovf_cnt), .OVF_CLR(clr)
    );

    error_fifo_mc #(.NSRC(4), .SW(32), .TAGW(24), .DEPTH_LOG(2)) dut_small (
        .CLK(clk), .RESET(rst), .CPSR(24'h0), .SRC_STB(s_stb), .SRC_ECD(s_ecd_in),
        .ERD(s_erd), .VALID(s_valid), .ECD(s_ecd), .COUNT(s_count), .OVF(s_ovf),
        .OVF_CNT(s_ovf_cnt), .OVF_CLR(1'b0)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: capture slots, occupancy counts and the stored-entry queue
    always @(posedge clk) begin : ref_model
        int g;
        int drops;
        bit full;
        bit load;
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                m_full[i] = 1'b0; m_lostflag[i] = 1'b0; m_caplost[i] = 1'b0;
            end
            m_rr = 0; m_ram_n = 0; m_out_v = 1'b0; m_ovf_cnt = 0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            g = -1;
            for (int k = 0; k < NSRC; k++)
                if (g < 0 && m_full[(m_rr + k) % NSRC]) g = (m_rr + k) % NSRC;
            full  = (m_ram_n == DEPTH);
            drops = 0;
            if (g >= 0) begin
                if (full) drops++;
                else exp_q.push_back({m_caplost[g], 7'(g), m_tag[g], m_pay[g]});
            end
            load    = (!m_out_v || erd) && (m_ram_n > 0);
            m_ram_n = m_ram_n + ((g >= 0 && !full) ? 1 : 0) - (load ? 1 : 0);
            m_out_v = load ? 1'b1 : (erd ? 1'b0 : m_out_v);
            if (g >= 0) begin
                m_full[g] = 1'b0;
                m_rr = (g + 1) % NSRC;
            end
            for (int i = 0; i < NSRC; i++) begin
                if (stb[i]) begin
                    if (!m_full[i]) begin
                        m_full[i] = 1'b1;
                        m_pay[i] = ecd_in[i*32 +: 32];
                        m_tag[i] = cpsr;
                        m_caplost[i] = m_lostflag[i];
                        m_lostflag[i] = 1'b0;
                    end else begin
                        drops++;
                        m_lostflag[i] = 1'b1;
                    end
                end
            end
            m_ovf_cnt = clr ? drops : m_ovf_cnt + drops;
            if (m_ovf_cnt > 65535) m_ovf_cnt = 65535;
            m_ovf = clr ? (drops != 0) : (m_ovf || drops != 0);
        end
    end

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (mon_en) begin
            check_output("valid", 64'(valid), 64'(m_out_v));
            check_output("count", 64'(count), 64'(m_ram_n + (m_out_v ? 1 : 0)));
            check_output("ovf", 64'(ovf), 64'(m_ovf));
            check_output("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf_cnt));
            if (valid && erd) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL pop_entry: got %h expected none queued", ecd);
                end else begin
                    e = exp_q.pop_front();
                    check_output("pop_entry", ecd, e);
                end
            end
        end
    end

    always @(negedge clk) begin : small_monitor
        logic [63:0] e;
        if (mon_en && s_valid && s_erd) begin
            if (small_q.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL small_pop: got %h expected none queued", s_ecd);
            end else begin
                e = small_q.pop_front();
                check_output("small_pop", s_ecd, e);
            end
        end
    end

    task automatic apply_stimulus(input logic [3:0] s, input logic [127:0] d,
                                  input logic [23:0] tag, input logic rd, input logic cl);
        @(posedge clk); #1;
        stb = s; ecd_in = d; cpsr = tag; erd = rd; clr = cl;
    endtask

    task automatic run_idle(input int n, input logic rd);
        repeat (n) apply_stimulus(4'b0, 128'd0, 24'd0, rd, 1'b0);
    endtask

    task automatic apply_random(input logic [3:0] s, input logic rd, input logic cl);
        apply_stimulus(s, {$urandom, $urandom, $urandom, $urandom}, 24'($urandom), rd, cl);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; stb = '0; erd = 1'b0; clr = 1'b0; s_stb = '0; s_erd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stb = '0; ecd_in = '0; cpsr = '0; erd = 1'b0; clr = 1'b0;
        s_stb = '0; s_ecd_in = '0; s_erd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_output("reset_valid", 64'(valid), 64'd0);
        check_output("reset_ecd", ecd, 64'd0);
        check_output("reset_count", 64'(count), 64'd0);

        // Depth-4 instance: 8 back-to-back reports, 5 kept, 3 discarded
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            s_stb = 4'b0001;
            s_ecd_in = {96'd0, 32'(k)};
            if (k < 5) small_q.push_back({8'h00, 24'h0, 32'(k)});
        end
        @(posedge clk); #1 s_stb = '0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_output("small_count", 64'(s_count), 64'd5);
        check_output("small_ovf_cnt", 64'(s_ovf_cnt), 64'd3);
        check_output("small_ovf", 64'(s_ovf), 64'd1);
        @(posedge clk); #1 s_erd = 1'b1;
        repeat (5) @(posedge clk);
        #1 s_erd = 1'b0;
        @(negedge clk);
        check_output("small_drained", 64'(s_valid), 64'd0);

        // Single report and three-cycle latency
        apply_reset();
        apply_stimulus(4'b0100, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, 24'h00A5A5, 1'b0, 1'b0);
        run_idle(2, 1'b0);
        @(negedge clk);
        check_output("lat_cycle2", 64'(valid), 64'd0);
        run_idle(1, 1'b0);
        @(negedge clk);
        check_output("lat_cycle3", 64'(valid), 64'd1);
        check_output("single_ecd", ecd, 64'h02_00A5A5_DEADBEEF);
        run_idle(1, 1'b1);
        run_idle(1, 1'b0);
        @(negedge clk);
        check_output("single_popped", 64'(valid), 64'd0);
        check_output("single_count", 64'(count), 64'd0);

        // Round robin: two full bursts, both drained in ID order
        apply_reset();
        apply_stimulus(4'b1111, {32'd3, 32'd2, 32'd1, 32'd0}, 24'h000001, 1'b0, 1'b0);
        run_idle(8, 1'b0);
        apply_stimulus(4'b1111, {32'd7, 32'd6, 32'd5, 32'd4}, 24'h000002, 1'b0, 1'b0);
        run_idle(8, 1'b0);
        @(negedge clk);
        check_output("rr_count", 64'(count), 64'd8);
        run_idle(10, 1'b1);

        // Capture overflow on source 1 while source 0 holds the grant
        apply_random(4'b1111, 1'b0, 1'b1);
        apply_random(4'b0010, 1'b0, 1'b0);
        apply_random(4'b0010, 1'b0, 1'b0);
        run_idle(6, 1'b0);
        @(negedge clk);
        check_output("capovf_cnt", 64'(ovf_cnt), 64'd1);
        check_output("capovf_flag", 64'(ovf), 64'd1);
        run_idle(12, 1'b1);

        // Random traffic: light then heavy backpressure
        for (int n = 0; n < 1500; n++)
            apply_random(4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0),
                         ($urandom_range(0, 63) == 0));
        for (int n = 0; n < 800; n++)
            apply_random(4'($urandom), ($urandom_range(0, 4) == 0),
                         ($urandom_range(0, 63) == 0));
        run_idle(80, 1'b1);

        // Reset in the middle of a stored stream
        apply_reset();
        apply_random(4'b1111, 1'b0, 1'b0);
        run_idle(4, 1'b0);
        apply_random(4'b0011, 1'b0, 1'b0);
        run_idle(8, 1'b0);
        @(negedge clk);
        check_output("pre_reset_count", 64'(count), 64'd6);
        check_output("pre_reset_valid", 64'(valid), 64'd1);
        apply_reset();
        @(negedge clk);
        check_output("midreset_valid", 64'(valid), 64'd0);
        check_output("midreset_count", 64'(count), 64'd0);
        check_output("midreset_ovf", 64'(ovf), 64'd0);
        apply_stimulus(4'b0001, {96'd0, 32'h12345678}, 24'h0000C3, 1'b0, 1'b0);
        run_idle(2, 1'b0);
        @(negedge clk);
        check_output("post_reset_c2", 64'(valid), 64'd0);
        run_idle(1, 1'b0);
        @(negedge clk);
        check_output("post_reset_c3", 64'(valid), 64'd1);
        check_output("post_reset_ecd", ecd, 64'h00_0000C3_12345678);
        run_idle(4, 1'b1);

        // Counter saturation, then clear with one and with zero drops
        apply_reset();
        repeat (17000) apply_random(4'b1111, 1'b0, 1'b0);
        run_idle(1, 1'b0);
        @(negedge clk);
        check_output("sat_cnt", 64'(ovf_cnt), 64'hFFFF);
        check_output("sat_ovf", 64'(ovf), 64'd1);
        run_idle(80, 1'b1);
        apply_random(4'b0011, 1'b0, 1'b0);
        apply_random(4'b0011, 1'b0, 1'b1);
        apply_stimulus(4'b0, 128'd0, 24'd0, 1'b0, 1'b1);
        @(negedge clk);
        check_output("clr_one_cnt", 64'(ovf_cnt), 64'd1);
        check_output("clr_one_ovf", 64'(ovf), 64'd1);
        run_idle(1, 1'b0);
        @(negedge clk);
        check_output("clr_zero_cnt", 64'(ovf_cnt), 64'd0);
        check_output("clr_zero_ovf", 64'(ovf), 64'd0);
        run_idle(10, 1'b1);
        run_idle(2, 1'b0);

        @(negedge clk);
        check_output("final_queue", 64'(exp_q.size()), 64'd0);
        check_output("final_small_queue", 64'(small_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
